lcd_tile_fill_ctrl: RTL

Bus-side controller placed between the CPU bus and the RGB tile screen-memory port of the LCD block. It hosts a small register file through which software programs a rectangular tile-region fill. It then sequences one byte-wide write per tile onto the screen-memory port. CPU accesses to the same port are arbitrated against the engine, so software and hardware fills share one memory interface.

---
 rtl/lcd_tile_fill_ctrl_pkg.sv | 17 +
 rtl/lcd_port_arbiter.sv | 42 ++++
 rtl/lcd_tile_fill_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/lcd_tile_fill_ctrl_pkg.sv
// lcd_tile_fill_ctrl_pkg: screen geometry, register map and FSM states shared by the LCD tile fill controller
package lcd_tile_fill_ctrl_pkg;
  localparam int LCD_TILE_COLUMNS = 60;
  localparam int LCD_TILE_ROWS = 34;
  localparam int LCD_ADDR_WIDTH = 12;
  localparam logic [3:0] REG_CTRL = 4'h0;
  localparam logic [3:0] REG_ORIGIN = 4'h4;
  localparam logic [3:0] REG_SIZE = 4'h8;
  localparam logic [3:0] REG_VALUE = 4'hC;
  localparam int CTRL_START = 0;
  localparam int CTRL_BUSY = 0;
  localparam int CTRL_DONE = 1;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ISSUE, S_WAIT, S_NEXT, S_DONE} fill_state_t;
  function automatic logic [3:0] byte_strobe(input logic [1:0] a);
    return 4'b0001 << a;
  endfunction
endpackage

// File: rtl/lcd_port_arbiter.sv
// lcd_port_arbiter: CPU-priority mux onto the screen-memory port; an engine write in flight is never preempted
module lcd_port_arbiter
  import lcd_tile_fill_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = LCD_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_select,
  input  logic [3:0]            cpu_wstrb,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_data_i,
  output logic                  cpu_ready,
  output logic [31:0]           cpu_data_o,
  input  logic                  eng_req,
  input  logic                  eng_wait,
  input  logic [3:0]            eng_wstrb,
  input  logic [ADDR_WIDTH-1:0] eng_addr,
  input  logic [31:0]           eng_data,
  output logic                  eng_grant,
  output logic                  lcd_select,
  output logic [3:0]            lcd_wstrb,
  output logic [ADDR_WIDTH-1:0] lcd_addr,
  output logic [31:0]           lcd_data_o,
  input  logic                  lcd_ready,
  input  logic [31:0]           lcd_data_i
);
  logic cpu_own, cpu_fwd, eng_drive;
  assign cpu_fwd = rst_n && cpu_select && !eng_wait;
  // cpu_own keeps the engine off the port until the CPU's ready has been seen
  assign eng_grant = eng_req && !cpu_select && !cpu_own;
  assign eng_drive = eng_grant || eng_wait;
  assign lcd_select = cpu_fwd || eng_drive;
  assign lcd_wstrb = cpu_fwd ? cpu_wstrb : eng_drive ? eng_wstrb : '0;
  assign lcd_addr = cpu_fwd ? cpu_addr : eng_drive ? eng_addr : '0;
  assign lcd_data_o = cpu_fwd ? cpu_data_i : eng_drive ? eng_data : '0;
  assign cpu_ready = cpu_fwd && lcd_ready;
  assign cpu_data_o = cpu_ready ? lcd_data_i : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cpu_own <= 1'b0;
    else cpu_own <= lcd_ready ? 1'b0 : cpu_fwd ? 1'b1 : cpu_own;
endmodule

// File: rtl/lcd_tile_fill_ctrl.sv
// lcd_tile_fill_ctrl: register-programmed rectangular tile fill sequenced onto the shared screen-memory port
module lcd_tile_fill_ctrl
  import lcd_tile_fill_ctrl_pkg::*;
#(
  parameter int TILE_COLUMNS = LCD_TILE_COLUMNS,
  parameter int TILE_ROWS = LCD_TILE_ROWS,
  parameter int ADDR_WIDTH = LCD_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reg_select,
  input  logic [3:0]            reg_wstrb,
  input  logic [3:0]            reg_addr,
  input  logic [31:0]           reg_data_i,
  output logic                  reg_ready,
  output logic [31:0]           reg_data_o,
  input  logic                  cpu_select,
  input  logic [3:0]            cpu_wstrb,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_data_i,
  output logic                  cpu_ready,
  output logic [31:0]           cpu_data_o,
  output logic                  lcd_select,
  output logic [3:0]            lcd_wstrb,
  output logic [ADDR_WIDTH-1:0] lcd_addr,
  output logic [31:0]           lcd_data_o,
  input  logic                  lcd_ready,
  input  logic [31:0]           lcd_data_i,
  output logic                  busy,
  output logic                  done_pulse
);
  localparam logic [6:0] COLS = 7'(TILE_COLUMNS);
  localparam logic [6:0] ROWS = 7'(TILE_ROWS);
  fill_state_t state, state_nx;
  logic [5:0] x0_q, y0_q, x0_f, x_end, y_end, x, y;
  logic [6:0] w_q, h_q, x_sum, y_sum;
  logic [7:0] value_q, val_f;
  logic [ADDR_WIDTH-1:0] row_base, eng_addr;
  logic [31:0] ctrl_rd, rdata;
  logic done_sticky, reg_acc, reg_wr, idle, start, degenerate, last_col, last_row;
  logic eng_req, eng_wait, eng_grant;
  logic unused_ok;
  assign unused_ok = ^{reg_data_i[31:23], reg_data_i[15:8]};
  assign reg_acc = reg_select && !reg_ready;
  assign reg_wr = reg_acc && |reg_wstrb;
  assign idle = state == S_IDLE || state == S_DONE;
  assign start = idle && reg_wr && reg_addr == REG_CTRL && reg_wstrb[0] && reg_data_i[CTRL_START];
  assign x_sum = {1'b0, x0_q} + w_q;
  assign y_sum = {1'b0, y0_q} + h_q;
  assign degenerate = w_q == '0 || h_q == '0 || {1'b0, x0_q} >= COLS || {1'b0, y0_q} >= ROWS;
  assign last_col = x + 6'd1 == x_end;
  assign last_row = y + 6'd1 == y_end;
  assign busy = !idle;
  assign done_pulse = state == S_DONE;
  assign eng_addr = row_base + ADDR_WIDTH'(x);
  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_BUSY] = busy;
    ctrl_rd[CTRL_DONE] = done_sticky;
    rdata = reg_addr == REG_CTRL ? ctrl_rd :
            reg_addr == REG_ORIGIN ? {10'b0, y0_q, 10'b0, x0_q} :
            reg_addr == REG_SIZE ? {9'b0, h_q, 9'b0, w_q} :
            reg_addr == REG_VALUE ? {24'b0, value_q} : '0;
  end
  always_comb begin
    state_nx = state;
    eng_req = 1'b0;
    eng_wait = 1'b0;
    case (state)
      S_IDLE, S_DONE: state_nx = start ? (degenerate ? S_DONE : S_SETUP) : S_IDLE;
      S_SETUP: state_nx = S_ISSUE;
      S_ISSUE: begin
        eng_req = 1'b1;
        state_nx = eng_grant ? S_WAIT : S_ISSUE;
      end
      S_WAIT: begin
        eng_wait = 1'b1;
        state_nx = lcd_ready ? S_NEXT : S_WAIT;
      end
      S_NEXT: state_nx = !last_col ? S_ISSUE : last_row ? S_DONE : S_SETUP;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      reg_ready <= 1'b0;
      reg_data_o <= '0;
      x0_q <= '0;
      y0_q <= '0;
      w_q <= '0;
      h_q <= '0;
      value_q <= '0;
      done_sticky <= 1'b0;
      x0_f <= '0;
      x_end <= '0;
      y_end <= '0;
      x <= '0;
      y <= '0;
      val_f <= '0;
      row_base <= '0;
    end else begin
      state <= state_nx;
      reg_ready <= reg_select && !reg_ready;
      reg_data_o <= (reg_acc && !reg_wr) ? rdata : '0;
      if (reg_wr && reg_addr == REG_ORIGIN) begin
        if (reg_wstrb[0]) x0_q <= reg_data_i[5:0];
        if (reg_wstrb[2]) y0_q <= reg_data_i[21:16];
      end
      if (reg_wr && reg_addr == REG_SIZE) begin
        if (reg_wstrb[0]) w_q <= reg_data_i[6:0];
        if (reg_wstrb[2]) h_q <= reg_data_i[22:16];
      end
      if (reg_wr && reg_addr == REG_VALUE && reg_wstrb[0]) value_q <= reg_data_i[7:0];
      if (state == S_DONE) done_sticky <= 1'b1;
      else if (reg_wr && reg_addr == REG_CTRL) done_sticky <= 1'b0;
      if (start) begin
        x0_f <= x0_q;
        x <= x0_q;
        y <= y0_q;
        x_end <= 6'(x_sum > COLS ? COLS : x_sum);
        y_end <= 6'(y_sum > ROWS ? ROWS : y_sum);
        val_f <= value_q;
      end
      if (state == S_SETUP) row_base <= ADDR_WIDTH'(y) * ADDR_WIDTH'(TILE_COLUMNS);
      if (state == S_NEXT) begin
        x <= last_col ? x0_f : x + 6'd1;
        if (last_col) y <= y + 6'd1;
      end
    end
  lcd_port_arbiter #(.ADDR_WIDTH(ADDR_WIDTH)) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_select (cpu_select),
    .cpu_wstrb  (cpu_wstrb),
    .cpu_addr   (cpu_addr),
    .cpu_data_i (cpu_data_i),
    .cpu_ready  (cpu_ready),
    .cpu_data_o (cpu_data_o),
    .eng_req    (eng_req),
    .eng_wait   (eng_wait),
    .eng_wstrb  (byte_strobe(eng_addr[1:0])),
    .eng_addr   (eng_addr),
    .eng_data   ({4{val_f}}),
    .eng_grant  (eng_grant),
    .lcd_select (lcd_select),
    .lcd_wstrb  (lcd_wstrb),
    .lcd_addr   (lcd_addr),
    .lcd_data_o (lcd_data_o),
    .lcd_ready  (lcd_ready),
    .lcd_data_i (lcd_data_i)
  );
endmodule
